// File: rtl/jk_pkg.sv
// Shared JK excitation codes and counter operation encoding for the JK counter slice.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_LOAD = 2'd3
  } op_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with asynchronous active-low clear.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TOG:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter: computes per-bit JK excitation and drives a bank of jk_cell flops.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             load_err,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec
);

  // One extra bit so MODULUS = 2**WIDTH compares without overflow.
  localparam int unsigned XW = WIDTH + 1;
  localparam logic [XW-1:0] MOD_X = XW'(MODULUS);
  localparam logic [XW-1:0] MAX_X = XW'(MODULUS - 1);

  op_t              op;
  logic [XW-1:0]    q_x;
  logic [XW-1:0]    din_x;
  logic [WIDTH-1:0] n;
  logic             load_oor;
  logic [1:0]       code [WIDTH];

  assign q_x   = {1'b0, q};
  assign din_x = {1'b0, din};

  // Operation select: load beats count, count beats hold.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = up ? OP_UP : OP_DOWN;
    end
  end

  // Next-state value; any out-of-range q counting up lands on 0 so a corrupted state recovers.
  always_comb begin
    n        = q;
    load_oor = 1'b0;
    case (op)
      OP_LOAD: begin
        if (din_x < MOD_X) begin
          n = din;
        end else begin
          n        = '0;
          load_oor = 1'b1;
        end
      end
      OP_UP:   n = (q_x >= MAX_X) ? '0 : q + WIDTH'(1);
      OP_DOWN: n = (q_x == '0) ? WIDTH'(MAX_X) : q - WIDTH'(1);
      default: n = q;
    endcase
  end

  // Excitation encoder: load always forces set/reset, count only toggles changing bits.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      code[i] = JK_HOLD;
      case (op)
        OP_LOAD:        code[i] = n[i] ? JK_SET : JK_RST;
        OP_UP, OP_DOWN: code[i] = (n[i] ^ q[i]) ? JK_TOG : JK_HOLD;
        default:        code[i] = JK_HOLD;
      endcase
      j_vec[i] = code[i][1];
      k_vec[i] = code[i][0];
    end
  end

  assign tc = en & ~load & ((up & (q_x == MAX_X)) | (~up & (q_x == '0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load_oor;
    end
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_vec[g]),
      .k     (k_vec[g]),
      .q     (q[g]),
      .qb    (qb[g])
    );
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: a 4-bit mod-10 instance and a 3-bit mod-8 instance.
module tb_jk_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=4, MODULUS=10
  logic       reset0 = 1'b0, en0 = 1'b0, up0 = 1'b0, load0 = 1'b0;
  logic [3:0] din0 = '0;
  logic [3:0] q0, qb0, j0, k0;
  logic       tc0, err0;

  // Instance 1: WIDTH=3, MODULUS=8
  logic       reset1 = 1'b0, en1 = 1'b0, up1 = 1'b0, load1 = 1'b0;
  logic [2:0] din1 = '0;
  logic [2:0] q1, qb1, j1, k1;
  logic       tc1, err1;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut0 (
    .clk(clk), .reset(reset0), .en(en0), .up(up0), .load(load0), .din(din0),
    .q(q0), .qb(qb0), .tc(tc0), .load_err(err0), .j_vec(j0), .k_vec(k0)
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut1 (
    .clk(clk), .reset(reset1), .en(en1), .up(up1), .load(load1), .din(din1),
    .q(q1), .qb(qb1), .tc(tc1), .load_err(err1), .j_vec(j1), .k_vec(k1)
  );

  typedef struct {
    int         idx;
    logic       sel;
    logic [3:0] q;
    logic       tc;
    logic [3:0] j;
    logic [3:0] k;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL v%0d %s got %b want %b", idx, nm, got, want);
    end
  endtask

  // Drive one cycle of stimulus after the falling edge and queue what the DUT should show.
  task automatic step(input logic sel, input logic rst, input logic ld, input logic e,
                      input logic u, input logic [3:0] d, input logic [3:0] eq,
                      input logic etc, input logic [3:0] ej, input logic [3:0] ek,
                      input logic eerr);
    exp_t x;
    @(negedge clk);
    if (!sel) begin
      reset0 = rst; load0 = ld; en0 = e; up0 = u; din0 = d;
    end else begin
      reset1 = rst; load1 = ld; en1 = e; up1 = u; din1 = d[2:0];
    end
    #2;
    x.idx = vec_n; x.sel = sel; x.q = eq; x.tc = etc; x.j = ej; x.k = ek; x.err = eerr;
    exp_q.push_back(x);
    vec_n++;
  endtask

  // Monitor: settles after the drive point, pops the pending expectation and compares.
  initial begin
    exp_t e;
    logic [3:0] want_qb;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          want_qb = ~e.q;
          chk("q",        e.idx, q0, e.q);
          chk("qb",       e.idx, qb0, want_qb);
          chk("tc",       e.idx, {3'b000, tc0}, {3'b000, e.tc});
          chk("j_vec",    e.idx, j0, e.j);
          chk("k_vec",    e.idx, k0, e.k);
          chk("load_err", e.idx, {3'b000, err0}, {3'b000, e.err});
        end else begin
          want_qb = {1'b0, ~e.q[2:0]};
          chk("q",        e.idx, {1'b0, q1}, e.q);
          chk("qb",       e.idx, {1'b0, qb1}, want_qb);
          chk("tc",       e.idx, {3'b000, tc1}, {3'b000, e.tc});
          chk("j_vec",    e.idx, {1'b0, j1}, e.j);
          chk("k_vec",    e.idx, {1'b0, k1}, e.k);
          chk("load_err", e.idx, {3'b000, err1}, {3'b000, e.err});
        end
      end
    end
  end

  initial begin
    // sel rst ld en up din   q  tc j       k       err
    step(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 4'b0000, 0);
    // count up through the wrap
    step(0, 1, 0, 1, 1, 4'd0, 4'd0, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd1, 0, 4'b0011, 4'b0011, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd2, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd3, 0, 4'b0111, 4'b0111, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd4, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd5, 0, 4'b0011, 4'b0011, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd6, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd7, 0, 4'b1111, 4'b1111, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd8, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd9, 1, 4'b1001, 4'b1001, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd0, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd1, 0, 4'b0011, 4'b0011, 0);
    // load 3, count down through the wrap
    step(0, 1, 1, 0, 0, 4'd3, 4'd2, 0, 4'b0011, 4'b1100, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd3, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd2, 0, 4'b0011, 4'b0011, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd1, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd0, 1, 4'b1001, 4'b1001, 0);
    step(0, 1, 0, 1, 0, 4'd0, 4'd9, 0, 4'b0001, 4'b0001, 0);
    // out-of-range load clamps to 0 with a one-cycle error pulse
    step(0, 1, 1, 0, 0, 4'd12, 4'd8, 0, 4'b0000, 4'b1111, 0);
    step(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 4'b0000, 1);
    step(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 4'b0000, 0);
    // load and en together: load wins, no toggle codes
    step(0, 1, 1, 0, 0, 4'd7, 4'd0, 0, 4'b0111, 4'b1000, 0);
    step(0, 1, 1, 1, 1, 4'd5, 4'd7, 0, 4'b0101, 4'b1010, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd5, 0, 4'b0011, 4'b0011, 0);
    // asynchronous reset from q=6, then release
    step(0, 0, 0, 1, 1, 4'd0, 4'd0, 0, 4'b0001, 4'b0001, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd0, 0, 4'b0001, 4'b0001, 0);
    // hold, direction changes while disabled are ignored
    step(0, 1, 0, 0, 0, 4'd0, 4'd1, 0, 4'b0000, 4'b0000, 0);
    step(0, 1, 0, 0, 1, 4'd0, 4'd1, 0, 4'b0000, 4'b0000, 0);
    // load onto terminal value with en: tc suppressed, set/reset even when n equals q
    step(0, 1, 1, 0, 0, 4'd9, 4'd1, 0, 4'b1001, 4'b0110, 0);
    step(0, 1, 1, 1, 1, 4'd9, 4'd9, 0, 4'b1001, 4'b0110, 0);
    step(0, 1, 0, 1, 1, 4'd0, 4'd9, 1, 4'b1001, 4'b1001, 0);
    step(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 4'b0000, 0);
    // full-range modulus on the 3-bit instance
    step(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 4'b0000, 0);
    step(1, 1, 1, 0, 0, 4'd7, 4'd0, 0, 4'b0111, 4'b0000, 0);
    step(1, 1, 0, 1, 1, 4'd0, 4'd7, 1, 4'b0111, 4'b0111, 0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 4'b0000, 0);
    step(1, 1, 0, 0, 1, 4'd0, 4'd0, 0, 4'b0000, 4'b0000, 0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd0, 0, 4'b0000, 4'b0000, 0);
    step(1, 1, 0, 1, 0, 4'd0, 4'd0, 1, 4'b0111, 4'b0111, 0);
    step(1, 1, 0, 0, 0, 4'd0, 4'd7, 0, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
